// File: rtl/lzd_seq_norm.sv
// lzd_seq_norm -- sequential leading-zero normalizer.
//
// An accepted operand is scanned one nibble per cycle, most significant
// nibble first, until the first nonzero nibble is found. That nibble's
// position gives the leading-zero count. A single barrel shift then
// normalizes the operand so that its MSB is set.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   [W-1:0] operand
//   in_valid   in   operand valid
//   in_ready   out  block is idle and can accept an operand
//   out_mant   out  [W-1:0] normalized operand (0 for an all-zero operand)
//   out_lz     out  [CW-1:0] leading-zero count, 0..W
//   out_zero   out  operand was all zeros (out_lz == W)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer takes the result
//   busy       out  FSM is not in IDLE
//   dbg_state  out  [1:0] current FSM state, for checkers
//
// Handshakes use valid/ready semantics. A transfer happens on a rising
// edge where valid & ready are both high. A producer must hold its payload
// stable while valid is high and ready is low. Here, in_ready is high only
// in IDLE. out_valid is high only in DONE, where the outputs are frozen.
module lzd_seq_norm #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_mant,
  output logic [CW-1:0] out_lz,
  output logic          out_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // The nibble index runs from 0 to W/4-1. That range always fits in CW-2 bits.
  localparam int             IW       = CW - 2;
  localparam logic [IW-1:0]  LAST_IDX = IW'(W / 4 - 1);
  localparam logic [CW-1:0]  LZ_ALL   = CW'(W);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] lz_q, lz_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          zero_q, zero_d;
  // Keeps in_ready low from reset until the first clock edge after release.
  logic          started_q;

  // 2-bit leading-zero detector: returns {valid, position}.
  function automatic logic [1:0] lzd2(input logic [1:0] b);
    return {|b, ~b[1]};
  endfunction

  // Select the nibble addressed by the current index (index 0 = top nibble).
  logic [3:0] nib;
  always_comb begin
    nib = '0;
    for (int i = 0; i < W / 4; i++) begin
      if (idx_q == IW'(i)) nib = data_q[W-1-4*i -: 4];
    end
  end

  // The 4-bit LZD merges two 2-bit LZDs. If the upper pair is nonzero it
  // decides the position. Otherwise the lower pair decides it, offset by 2.
  logic [1:0] hi_lzd, lo_lzd;
  logic       nib_v;
  logic [1:0] nib_pos;
  always_comb begin
    hi_lzd  = lzd2(nib[3:2]);
    lo_lzd  = lzd2(nib[1:0]);
    nib_v   = hi_lzd[1] | lo_lzd[1];
    nib_pos = hi_lzd[1] ? {1'b0, hi_lzd[0]} : {1'b1, lo_lzd[0]};
  end

  assign in_ready  = (state_q == IDLE) & started_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_mant  = data_q;
  assign out_lz    = lz_q;
  assign out_zero  = zero_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lz_d    = lz_q;
    idx_d   = idx_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          lz_d    = '0;
          idx_d   = '0;
          zero_d  = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (nib_v) begin
          lz_d    = lz_q + {{(CW-2){1'b0}}, nib_pos};
          state_d = SHIFT;
        end else if (idx_q == LAST_IDX) begin
          // All nibbles are zero. The register already holds 0, so no shift is needed.
          lz_d    = LZ_ALL;
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          lz_d  = lz_q + CW'(4);
          idx_d = idx_q + IW'(1);
        end
      end
      SHIFT: begin
        data_d  = data_q << lz_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      lz_q      <= '0;
      idx_q     <= '0;
      zero_q    <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      lz_q      <= lz_d;
      idx_q     <= idx_d;
      zero_q    <= zero_d;
      started_q <= 1'b1;
    end
  end

endmodule

// File: doc/lzd_seq_norm.md
LZD_SEQ_NORM -- requirements
Module: lzd_seq_norm

Interface
REQ-001 Parameter W, default 32: data width; SHALL be a multiple of 4 and in the range 8..64.
REQ-002 Parameter CW, default 6: count width; SHALL equal clog2(W)+1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  W  unsigned operand to normalize.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 out_mant  output  W  normalized operand, MSB = 1 unless out_zero.
REQ-009 out_lz  output  CW  leading-zero count of the accepted operand.
REQ-010 out_zero  output  1  accepted operand was all zeros.
REQ-011 out_valid  output  1  out_mant/out_lz/out_zero are valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SCAN, SHIFT and DONE, with one state per clock cycle.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-016 On accept, the FSM SHALL capture in_data into an internal register, clear lz and the nibble index, and go to SCAN.
REQ-017 In SCAN, each cycle SHALL examine one nibble, MSB first: index i covers bits [W-1-4i : W-4-4i].
REQ-018 Nibble examination SHALL use a 4-bit leading-zero detector (two 2-bit LZDs plus a merge) returning valid and position 0..3.
REQ-019 Nonzero nibble in SCAN: lz SHALL become lz + position, and the FSM SHALL go to SHIFT.
REQ-020 Zero nibble that is not the last: lz SHALL increment by 4, the index SHALL increment, and the FSM SHALL stay in SCAN.
REQ-021 Zero nibble that is the last (i = W/4-1): lz SHALL become W, the zero flag SHALL be set, and the FSM SHALL go to DONE without passing through SHIFT.
REQ-022 SHIFT: the register SHALL be loaded with (register << lz) in a single cycle, and the FSM SHALL go to DONE.
REQ-023 DONE: out_valid SHALL be 1; outputs SHALL hold stable until out_valid & out_ready.
REQ-024 DONE with out_ready = 1: the FSM SHALL return to IDLE next cycle; with out_ready = 0 it SHALL stay in DONE indefinitely.
REQ-025 Latency: k = index of the first nonzero nibble; out_valid SHALL first assert k+3 cycles after the accept edge. An all-zero operand SHALL give W/4+1 cycles.
REQ-026 out_lz SHALL lie in 0..W; out_zero = 1 if and only if out_lz = W, in which case out_mant = 0.
REQ-027 in_valid and in_data SHALL be ignored outside IDLE; no operand is queued.
REQ-028 Throughput: a new accept SHALL be possible no earlier than the cycle after the DONE handshake.
REQ-029 out_valid SHALL be 0 in IDLE, SCAN and SHIFT; out_mant, out_lz and out_zero SHALL be registered outputs.

Reset
REQ-030 While rst_n = 0, immediately and regardless of clk: state = IDLE, out_mant = 0, out_lz = 0, out_zero = 0, out_valid = 0, busy = 0, in_ready = 0.
REQ-031 The first rising edge with rst_n = 1 SHALL leave in_ready = 1.
REQ-032 Reset asserted in any state, including mid-SCAN and DONE with out_ready = 0, SHALL discard the in-flight operand; no out_valid SHALL follow deassertion without a new accept.

Verification
REQ-033 Operand 0x8000_0000 -> out_valid 3 cycles after accept; out_lz = 0, out_mant = 0x8000_0000, out_zero = 0.
REQ-034 Operand 0x0000_0001 -> out_valid after 10 cycles; out_lz = 31, out_mant = 0x8000_0000.
REQ-035 Operand 0x0000_0000 -> out_valid after 9 cycles; out_lz = 32, out_zero = 1, out_mant = 0.
REQ-036 Operand 0x0012_3456, with out_ready held 0 for 5 cycles in DONE -> out_lz = 11, out_mant = 0x91A2_B000, outputs held stable throughout; in_ready = 1 the cycle after the handshake.
REQ-037 in_valid pulsed with 0xFFFF_FFFF during SCAN of operand 0x0F00_0000 -> the pulse is ignored; result out_lz = 4, out_mant = 0xF000_0000.
REQ-038 rst_n pulsed low in SCAN -> all outputs 0 asynchronously; no out_valid until the next accept; the next operand 0x4000_0000 -> out_lz = 1.
